// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM states and ROM size.
package cpu_pkg;

    localparam int ROM_DEPTH = 128;

    // Two-byte instructions: loads/stores with an immediate or direct operand
    localparam logic [7:0] LDA_IMM = 8'h86;
    localparam logic [7:0] LDA_DIR = 8'h87;
    localparam logic [7:0] LDB_IMM = 8'h88;
    localparam logic [7:0] LDB_DIR = 8'h89;
    localparam logic [7:0] STA_DIR = 8'h96;
    localparam logic [7:0] STB_DIR = 8'h97;

    // Two-byte branches occupy BRA..BCC contiguously
    localparam logic [7:0] BRA = 8'h20;
    localparam logic [7:0] BCC = 8'h28;

    // One-byte register ops occupy ADD_AB..ADDAB_LDB contiguously
    localparam logic [7:0] ADD_AB    = 8'h42;
    localparam logic [7:0] ADDAB_LDB = 8'h4D;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_OPCODE,
        ST_OPERAND,
        ST_HOLD,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: ROM read port, instruction bundle handshake, branch redirect.
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_opcode;
    logic [DATA_W-1:0] instr_operand;
    logic              instr_has_arg;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              fault;

    // Fetch unit side
    modport master (
        output rom_address, instr_valid, instr_opcode, instr_operand,
               instr_has_arg, instr_pc, fault,
        input  rom_data, instr_ready, redirect, redirect_addr
    );

    // ROM / execute side
    modport slave (
        input  rom_address, instr_valid, instr_opcode, instr_operand,
               instr_has_arg, instr_pc, fault,
        output rom_data, instr_ready, redirect, redirect_addr
    );
endinterface

// File: rtl/opcode_class.sv
// Opcode classifier: legality and instruction length; shared with the decoder.
module opcode_class
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       legal,
    output logic       has_arg
);
    logic two_byte;
    logic one_byte;

    // Table lookup of the opcode map
    always_comb begin
        two_byte = opcode inside {[LDA_IMM:LDB_DIR], STA_DIR, STB_DIR, [BRA:BCC]};
        one_byte = opcode inside {[ADD_AB:ADDAB_LDB]};
        legal    = two_byte | one_byte;
        has_arg  = two_byte;
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the 1-cycle-latency program ROM, assembles
// 1/2-byte instructions and offers them over valid/ready.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_FETCH   | ROM address = pc; range-check pc
//   ST_OPCODE  | opcode byte on rom_data; classify, request operand
//   ST_OPERAND | operand byte on rom_data; pc advances by 2
//   ST_HOLD    | bundle valid, waiting for instr_ready
//   ST_HALT    | fault latched; only reset leaves this state
module instr_fetch #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int ROM_DEPTH = cpu_pkg::ROM_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    import cpu_pkg::*;

    // Range compares use one extra bit so pc+1 cannot wrap past the check
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(ROM_DEPTH - 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              valid_q;
    logic [DATA_W-1:0] opcode_q;
    logic [DATA_W-1:0] operand_q;
    logic              has_arg_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              fault_q;

    logic op_legal;
    logic op_has_arg;
    logic pc_oob;
    logic next_oob;

    opcode_class u_opcode_class (
        .opcode  (bus.rom_data),
        .legal   (op_legal),
        .has_arg (op_has_arg)
    );

    assign pc_oob   = {1'b0, pc} > LAST_ADDR;
    assign next_oob = ({1'b0, pc} + (ADDR_W+1)'(1)) > LAST_ADDR;

    // ROM address: operand prefetch only when the operand byte is in range
    always_comb begin
        bus.rom_address = pc;
        if (state == ST_OPCODE && op_legal && op_has_arg && !next_oob)
            bus.rom_address = pc + ADDR_W'(1);
    end

    // Fetch FSM with registered bundle outputs; redirect beats all but reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= '0;
            valid_q    <= 1'b0;
            opcode_q   <= '0;
            operand_q  <= '0;
            has_arg_q  <= 1'b0;
            instr_pc_q <= '0;
            fault_q    <= 1'b0;
        end else if (state != ST_HALT && bus.redirect) begin
            pc      <= bus.redirect_addr;
            state   <= ST_FETCH;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (pc_oob) begin
                        state   <= ST_HALT;
                        fault_q <= 1'b1;
                    end else begin
                        state <= ST_OPCODE;
                    end
                end
                ST_OPCODE: begin
                    opcode_q   <= bus.rom_data;
                    instr_pc_q <= pc;
                    has_arg_q  <= op_has_arg;
                    if (!op_legal || (op_has_arg && next_oob)) begin
                        state   <= ST_HALT;
                        fault_q <= 1'b1;
                    end else if (op_has_arg) begin
                        state <= ST_OPERAND;
                    end else begin
                        operand_q <= '0;
                        pc        <= pc + ADDR_W'(1);
                        valid_q   <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_OPERAND: begin
                    operand_q <= bus.rom_data;
                    pc        <= pc + ADDR_W'(2);
                    valid_q   <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state   <= ST_HALT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.instr_valid   = valid_q;
    assign bus.instr_opcode  = opcode_q;
    assign bus.instr_operand = operand_q;
    assign bus.instr_has_arg = has_arg_q;
    assign bus.instr_pc      = instr_pc_q;
    assign bus.fault         = fault_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized ROM walk
// checked against a bundle-level model of the fetch rules.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   acc_cnt = 0;
    bit   oob_read = 1'b0;
    logic [7:0] rom [0:255];

    instr_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Registered ROM model plus acceptance and out-of-range-read monitors
    always @(posedge clk) begin
        bus.rom_data <= rom[bus.rom_address];
        if (!reset && bus.instr_valid && bus.instr_ready) acc_cnt <= acc_cnt + 1;
        if (!reset && bus.rom_address > 8'd127) oob_read <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!bus.instr_valid && n < maxc) begin
            tick();
            n++;
        end
        chk("valid_timeout", bus.instr_valid, 1);
    endtask

    function automatic bit is2(input logic [7:0] op);
        return op inside {[8'h86:8'h89], 8'h96, 8'h97, [8'h20:8'h28]};
    endfunction

    function automatic bit is1(input logic [7:0] op);
        return op inside {[8'h42:8'h4D]};
    endfunction

    // Bundle-level model: what the instruction at pc looks like and where the next one starts
    function automatic void model(input int pc, output int op, output int arg,
                                  output bit has, output bit ok, output int npc);
        op  = (pc < 128) ? int'(rom[pc]) : 0;
        has = is2(8'(op));
        ok  = (pc < 128) && (is1(8'(op)) || (has && pc + 1 < 128));
        arg = has && pc + 1 < 128 ? int'(rom[pc+1]) : 0;
        npc = (pc + (has ? 2 : 1)) % 256;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] bytes [$]);
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        foreach (bytes[i]) rom[i] = bytes[i];
    endtask

    task automatic chk_bundle(input string tag, input int pc);
        int op, arg, npc;
        bit has, ok;
        model(pc, op, arg, has, ok, npc);
        chk({tag, "_op"},  bus.instr_opcode, op);
        chk({tag, "_arg"}, bus.instr_operand, arg);
        chk({tag, "_has"}, bus.instr_has_arg, has);
        chk({tag, "_pc"},  bus.instr_pc, pc);
    endtask

    initial begin
        int n, acc0, mpc, op, arg, npc, guard;
        bit has, ok, r;
        logic [7:0] p1 [$];
        logic [7:0] legal_ops [$];

        bus.instr_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        bus.rom_data = '0;

        // 1: reset values, then latency and spacing with ready held high
        p1 = '{8'h86, 8'h00, 8'h88, 8'h01, 8'h42, 8'h43};
        load(p1);
        reset = 1'b1;
        tick();
        tick();
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_addr", bus.rom_address, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_op", bus.instr_opcode, 0);
        chk("rst_arg", bus.instr_operand, 0);
        chk("rst_has", bus.instr_has_arg, 0);
        chk("rst_pc", bus.instr_pc, 0);
        reset = 1'b0;
        wait_valid(10, n);
        chk("t1_lat0", n, 3);
        chk_bundle("t1_b0", 0);
        tick();
        chk("t1_vfall", bus.instr_valid, 0);
        wait_valid(10, n);
        chk("t1_space1", n + 1, 4);
        chk_bundle("t1_b1", 2);
        tick();
        wait_valid(10, n);
        chk("t1_space2", n + 1, 3);
        chk_bundle("t1_b2", 4);

        // 2: stall on bundle at pc 2; outputs and ROM address frozen
        do_reset();
        bus.instr_ready = 1'b1;
        wait_valid(10, n);
        tick();
        bus.instr_ready = 1'b0;
        wait_valid(10, n);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_valid", bus.instr_valid, 1);
            chk_bundle("t2_hold", 2);
            chk("t2_addr", bus.rom_address, 4);
        end
        bus.instr_ready = 1'b1;
        tick();
        chk("t2_vfall", bus.instr_valid, 0);

        // 3: branch accepted together with redirect
        p1 = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h42, 8'h46, 8'h26, 8'h04, 8'h47};
        load(p1);
        do_reset();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_valid(10, n);
            if (bus.instr_pc == 8'd6) break;
            tick();
        end
        chk_bundle("t3_bvc", 6);
        acc0 = acc_cnt;
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'h04;
        tick();
        bus.redirect = 1'b0;
        chk("t3_accepted", acc_cnt, acc0 + 1);
        wait_valid(10, n);
        chk_bundle("t3_tgt", 4);

        // 3b: redirect in HOLD without ready drops the bundle
        bus.instr_ready = 1'b0;
        acc0 = acc_cnt;
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'h02;
        tick();
        bus.redirect = 1'b0;
        chk("t3b_dropped", acc_cnt, acc0);
        wait_valid(10, n);
        chk_bundle("t3b_tgt", 2);

        // 4: redirect during OPERAND of instruction at pc 2
        p1 = '{8'h86, 8'h00, 8'h88, 8'h01, 8'h42};
        load(p1);
        do_reset();
        bus.instr_ready = 1'b1;
        wait_valid(10, n);
        tick();
        tick();
        tick();
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'h00;
        tick();
        bus.redirect = 1'b0;
        wait_valid(10, n);
        chk("t4_pc", bus.instr_pc, 0);

        // 5: illegal opcode at 8 -> sticky fault, redirect ignored
        p1 = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'hFF};
        load(p1);
        do_reset();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_valid(10, n);
            chk_bundle("t5_walk", i);
            tick();
        end
        tick();
        chk("t5_fault_early", bus.fault, 0);
        tick();
        chk("t5_fault", bus.fault, 1);
        chk("t5_valid", bus.instr_valid, 0);
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'h00;
        tick();
        bus.redirect = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_fault_sticky", bus.fault, 1);
        chk("t5_valid_halt", bus.instr_valid, 0);
        chk("t5_addr_halt", bus.rom_address, 8);
        reset = 1'b1;
        tick();
        chk("t5_fault_clr", bus.fault, 0);
        reset = 1'b0;

        // 6: two-byte opcode at last ROM word, then reset during HOLD
        load(p1);
        rom[127] = 8'h86;
        do_reset();
        oob_read = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'd127;
        tick();
        bus.redirect = 1'b0;
        tick();
        chk("t6_opc_addr", bus.rom_address, 127);
        tick();
        chk("t6_fault", bus.fault, 1);
        chk("t6_valid", bus.instr_valid, 0);
        tick();
        chk("t6_no_oob_read", oob_read, 0);
        do_reset();
        bus.instr_ready = 1'b0;
        wait_valid(10, n);
        reset = 1'b1;
        tick();
        chk("t6_rst_valid", bus.instr_valid, 0);
        chk("t6_rst_addr", bus.rom_address, 0);
        reset = 1'b0;
        wait_valid(10, n);
        chk("t6_restart_pc", bus.instr_pc, 0);

        // Randomized ROM of legal opcodes, random ready, model-walked
        legal_ops = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h20, 8'h24, 8'h28,
                      8'h42, 8'h47, 8'h4D};
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        for (int i = 0; i < 128; i++)
            rom[i] = (i % 2 == 1 && $urandom_range(0, 1) == 1) ? 8'($urandom)
                   : legal_ops[$urandom_range(0, legal_ops.size() - 1)];
        do_reset();
        mpc = 0;
        for (int b = 0; b < 30; b++) begin
            model(mpc, op, arg, has, ok, npc);
            if (!ok) break;
            bus.instr_ready = 1'b0;
            wait_valid(10, n);
            chk("rnd_lat", n, has ? 3 : 2);
            chk_bundle("rnd", mpc);
            guard = 0;
            do begin
                r = ($urandom_range(0, 2) == 0);
                bus.instr_ready = r;
                tick();
                guard++;
                if (!r) begin
                    chk("rnd_stall_valid", bus.instr_valid, 1);
                    chk_bundle("rnd_stall", mpc);
                end
            end while (!r && guard < 20);
            if (!r) begin
                bus.instr_ready = 1'b1;
                tick();
            end
            chk("rnd_vfall", bus.instr_valid, 0);
            mpc = npc;
        end
        bus.instr_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator on the synchronous program-ROM read interface. It drives `rom_address` and captures `rom_data`, which is the registered ROM output with 1-cycle latency. It assembles 1- or 2-byte instructions and hands each one to the control/execute unit over a valid/ready handshake. Execute-stage branches redirect the fetch PC.

## Interface
- `ADDR_W`, 8, width of the ROM address and PC
- `DATA_W`, 8, width of the ROM data
- `ROM_DEPTH`, 128, number of valid ROM words; the highest legal address is `ROM_DEPTH-1`
- `clk`  in  1  clock; everything is on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `rom_address`  out  ADDR_W  ROM read address, combinational from state/PC
- `rom_data`  in  DATA_W  ROM output; holds `ROM[address]` from the previous cycle
- `instr_valid`  out  1  instruction bundle is valid
- `instr_ready`  in  1  execute unit accepts the bundle
- `instr_opcode`  out  DATA_W  opcode byte
- `instr_operand`  out  DATA_W  operand byte; 0 for 1-byte instructions
- `instr_has_arg`  out  1  1 for a 2-byte instruction
- `instr_pc`  out  ADDR_W  address of the opcode byte
- `redirect`  in  1  branch taken
- `redirect_addr`  in  ADDR_W  branch target
- `fault`  out  1  sticky: illegal opcode or out-of-range fetch

## Operation
- Opcode classes:
  - 2-byte: 0x86–0x89, 0x96, 0x97, 0x20–0x28.
  - 1-byte: 0x42–0x4D.
  - Everything else is illegal.
- States:
  - **FETCH**: `rom_address`=pc.
    - If pc > ROM_DEPTH-1, go to HALT.
    - Otherwise go to OPCODE.
  - **OPCODE**: capture `rom_data` into the opcode register and set `instr_pc`=pc.
    - 1-byte: pc<=pc+1, go to HOLD.
    - 2-byte: `rom_address`=pc+1. If pc+1 > ROM_DEPTH-1, go to HALT; otherwise go to OPERAND.
    - Illegal: go to HALT.
  - **OPERAND**: capture `rom_data` into the operand register, pc<=pc+2, go to HOLD.
  - **HOLD**: `instr_valid`=1. On `instr_ready`, go to FETCH.
  - **HALT**: `fault`=1 and `instr_valid`=0. The block leaves HALT only on reset, and `redirect` is ignored there.
- `rom_address` equals pc in HOLD and HALT.
- Redirect:
  - Applies in FETCH, OPCODE, OPERAND and HOLD: pc<=redirect_addr, go to FETCH, discard any partially assembled instruction.
  - Redirect has priority over every other transition except reset.
  - Redirect together with `instr_valid & instr_ready` in HOLD: the bundle counts as accepted, and the next fetch is from `redirect_addr`.
  - Redirect in HOLD without ready: the bundle is dropped and never counts as accepted.
- PC arithmetic is modulo 2^ADDR_W. Range faults are reached before any wrap.

## Timing
- Reset values: state=FETCH, pc=0, `rom_address`=0, `instr_valid`=0, `instr_opcode`=0, `instr_operand`=0, `instr_has_arg`=0, `instr_pc`=0, `fault`=0.
- Reset mid-operation: outputs return to their reset values at the next edge, and fetch restarts at 0.
- Latency from FETCH entry to `instr_valid`:
  - 1-byte instruction: 2 cycles.
  - 2-byte instruction: 3 cycles.
- Best-case throughput with ready held at 1:
  - 1-byte instruction: one every 3 cycles.
  - 2-byte instruction: one every 4 cycles.
- Handshake rules:
  - Once `instr_valid` rises, it and all `instr_*` outputs stay stable until `instr_ready` or `redirect`.
  - `instr_valid` falls the cycle after acceptance.
- `fault` rises in the cycle after the offending FETCH or OPCODE cycle.

## Structure
- Shared package (`cpu_pkg`):
  - opcode constants: LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR, STA_DIR, STB_DIR, ADD_AB…ADDAB_LDB, BRA…BCC
  - the state enum
  - ROM_DEPTH
- Sub-module `opcode_class`: combinational, `opcode` → {`legal`, `has_arg`}. It is reused by the decoder.

## Test plan
1. ROM 0x86,0x00,0x88,0x01,0x42; reset, then ready=1 → bundles (op 0x86, arg 0x00, pc 0), (0x88, 0x01, pc 2), (0x42, has_arg 0, pc 4), at 4-, 4- and 3-cycle spacing.
2. Hold `instr_ready`=0 for 5 cycles on bundle (0x88, pc 2) → valid and all `instr_*` stable, `rom_address` stays at 4, no further ROM reads.
3. BVC 0x26,0x04 at pc 6; accept with redirect=1 and `redirect_addr`=0x04 → next bundle is op 0x42, pc 4.
4. Redirect to 0x00 during OPERAND of the instruction at pc 2 → that instruction never becomes valid; next bundle is pc 0.
5. Opcode 0xFF at address 8 → `fault`=1 the cycle after OPCODE, valid stays 0, a redirect pulse is ignored, reset clears `fault`.
6. 2-byte opcode 0x86 at address 127 → HALT with `fault`=1 and no ROM read at 128; reset asserted during HOLD → valid=0 at the next edge and fetch restarts from 0.
